// File: rtl/ov7670_cap_pkg.sv
// Shared types and defaults for the OV7670 frame capture path.
package ov7670_cap_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT,
        WAIT_VS,
        SKIP,
        ARM,
        CAPTURE
    } cap_state_t;

    localparam int H_PIXELS_DEF    = 640;
    localparam int V_LINES_DEF     = 480;
    localparam int SKIP_FRAMES_DEF = 10;

    // RGB565 field positions inside sys_data_in
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/dvp_byte_pack.sv
// DVP front end: registers the camera pins, pairs bytes into 16-bit words
// and exposes the sync edges used by the capture FSM.
import ov7670_cap_pkg::*;

module dvp_byte_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        pix_stb,
    output logic [15:0] pix_data,
    output logic        href_fall,
    output logic        odd_flag,
    output logic        vs_rise,
    output logic        vs_fall
);

    logic       vsync_s1, vsync_s2;
    logic       href_s1, href_s2;
    logic [7:0] data_s1;
    logic [7:0] hi_byte;
    logic       tgl;

    // s1 captures the pins, s2 delays the sync lines for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_s1 <= 1'b0;
            vsync_s2 <= 1'b0;
            href_s1  <= 1'b0;
            href_s2  <= 1'b0;
            data_s1  <= 8'd0;
        end else begin
            vsync_s1 <= cam_vsync;
            vsync_s2 <= vsync_s1;
            href_s1  <= cam_href;
            href_s2  <= href_s1;
            data_s1  <= cam_data;
        end
    end

    // byte toggle: first byte of a pair is held, toggle resets between lines
    always_ff @(posedge clk) begin
        if (rst) begin
            tgl     <= 1'b0;
            hi_byte <= 8'd0;
        end else if (href_s1) begin
            tgl <= ~tgl;
            if (!tgl) hi_byte <= data_s1;
        end else begin
            tgl <= 1'b0;
        end
    end

    // low byte is in s1 while the toggle is set, so the pair is complete now
    assign pix_stb   = href_s1 & tgl;
    assign pix_data  = {hi_byte, data_s1};
    assign href_fall = href_s2 & ~href_s1;
    // toggle still holds the last line's parity in the href_fall cycle
    assign odd_flag  = tgl;
    assign vs_rise   = vsync_s1 & ~vsync_s2;
    assign vs_fall   = vsync_s2 & ~vsync_s1;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 capture: aligns to frame boundaries, skips settle frames and
// feeds only in-range RGB565 pixels of whole frames to the SDRAM write FIFO.
import ov7670_cap_pkg::*;

module ov7670_frame_capture #(
    parameter int H_PIXELS    = H_PIXELS_DEF,
    parameter int V_LINES     = V_LINES_DEF,
    parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic        frame_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam int PW = $clog2(H_PIXELS + 1);
    localparam int LW = $clog2(V_LINES + 1);
    localparam logic [PW-1:0] H_MAX = PW'(H_PIXELS);
    localparam logic [LW-1:0] L_MAX = LW'(V_LINES);

    cap_state_t    state, state_nx;
    logic          pix_stb, href_fall, odd_flag, vs_rise, vs_fall;
    logic [15:0]   pix_data;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [7:0]    skip_cnt;
    logic          err_flag;
    logic          start_frame, in_cap, end_frame, in_range;

    dvp_byte_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .pix_stb   (pix_stb),
        .pix_data  (pix_data),
        .href_fall (href_fall),
        .odd_flag  (odd_flag),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_INIT;
        else     state <= state_nx;
    end

    // next state and per-cycle frame strobes
    always_comb begin
        state_nx    = state;
        start_frame = 1'b0;
        in_cap      = 1'b0;
        end_frame   = 1'b0;
        in_range    = (pix_cnt < H_MAX) && (line_cnt < L_MAX);
        if (!sdram_init_done) begin
            state_nx = WAIT_INIT;
        end else begin
            case (state)
                WAIT_INIT: state_nx = WAIT_VS;
                WAIT_VS:
                    if (vs_rise) state_nx = (int'(skip_cnt) < SKIP_FRAMES) ? SKIP : ARM;
                SKIP:
                    if (vs_rise && (int'(skip_cnt) + 1 >= SKIP_FRAMES)) state_nx = ARM;
                ARM:
                    if (vs_fall) begin
                        state_nx    = CAPTURE;
                        start_frame = 1'b1;
                    end
                CAPTURE: begin
                    in_cap = 1'b1;
                    if (vs_rise) begin
                        state_nx  = ARM;
                        end_frame = 1'b1;
                    end
                end
                default: state_nx = WAIT_INIT;
            endcase
        end
    end

    // skip, pixel and line counters plus the running geometry error
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt <= 8'd0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            err_flag <= 1'b0;
        end else if (!sdram_init_done) begin
            skip_cnt <= 8'd0;
        end else begin
            if (state == SKIP && vs_rise) skip_cnt <= skip_cnt + 8'd1;
            if (start_frame) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                err_flag <= 1'b0;
            end
            if (in_cap && pix_stb) begin
                if (pix_cnt < H_MAX) pix_cnt <= pix_cnt + 1'b1;
                if (!in_range) err_flag <= 1'b1;
            end
            if (in_cap && href_fall) begin
                if (odd_flag || pix_cnt != H_MAX) err_flag <= 1'b1;
                if (line_cnt < L_MAX) line_cnt <= line_cnt + 1'b1;
                pix_cnt <= '0;
            end
        end
    end

    // FIFO write port and frame status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_we      <= 1'b0;
            sys_data_in <= 16'd0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            sys_we     <= 1'b0;
            frame_done <= 1'b0;
            if (!sdram_init_done) begin
                frame_valid <= 1'b0;
            end else begin
                if (start_frame) frame_valid <= 1'b1;
                // the closing pixel still lands even when vsync rises with it
                if (in_cap && pix_stb && in_range) begin
                    sys_we      <= 1'b1;
                    sys_data_in <= pix_data;
                end
                if (end_frame) begin
                    frame_valid <= 1'b0;
                    frame_done  <= 1'b1;
                    frame_err   <= err_flag | (line_cnt != L_MAX);
                    frame_cnt   <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/ov7670_frame_capture.md
Name: ov7670_frame_capture

Overview:
- Write-side counterpart of the SDRAM-to-VGA display path.
- Takes the OV7670 DVP byte stream (VSYNC/HREF/8-bit data) and packs byte pairs into RGB565 words.
- Drives the SDRAM write FIFO (sys_we/sys_data_in) and the frame_valid level that the bank switcher uses to flip write/read banks.
- Enforces frame alignment, sensor settle-frame skipping and geometry checking, so the FIFO only ever receives whole 640x480 frames.

Parameters:
H_PIXELS, 640, RGB565 pixels per line written to SDRAM
V_LINES, 480, lines per frame written to SDRAM
SKIP_FRAMES, 10, complete frames discarded after sdram_init_done before capture starts (0 allowed)

Ports:
clk  in  1  camera pixel clock (cam_pclk); all logic on rising edge
rst  in  1  synchronous active-high reset
sdram_init_done  in  1  SDRAM initialised; capture is gated by this
cam_vsync  in  1  OV7670 VSYNC, active-high between frames
cam_href  in  1  OV7670 HREF, high while line bytes are valid
cam_data  in  8  OV7670 D[7:0]
sys_we  out  1  FIFO write strobe, one cycle per pixel
sys_data_in  out  16  RGB565 pixel; first byte of the pair = [15:8]
frame_valid  out  1  high while a frame is being written; its falling edge marks the end of the frame
frame_done  out  1  one-cycle pulse at the end of each captured frame
frame_err  out  1  geometry error of the last finished frame; updated with frame_done
frame_cnt  out  8  captured-frame counter, wraps 255->0

Behaviour:
- Input registering: cam_vsync, cam_href and cam_data are registered once (stage s1). Edge detects compare s1 against a second stage, s2.
- Byte pairing:
  - With href_s1 high, a byte toggle alternates high/low.
  - The high byte is latched.
  - On the low byte, sys_data_in <= {hi, lo}, and sys_we is high on the next clk.
  - Latency: 2 clk from the low byte at the pins to sys_we.
  - The toggle clears when href_s1 is low.
- State machine:
  - WAIT_INIT:
    - Entered from reset; all outputs 0.
    - When sdram_init_done=1, go to WAIT_VS.
  - WAIT_VS: wait for a vsync rising edge, so a frame is never entered mid-way. Then:
    - skip_cnt < SKIP_FRAMES: go to SKIP.
    - otherwise: go to ARM.
  - SKIP: on each vsync rising edge, increment skip_cnt. When skip_cnt reaches SKIP_FRAMES, go to ARM.
  - ARM: on a vsync falling edge, clear the pixel and line counters and the error flag, set frame_valid=1, and go to CAPTURE.
  - CAPTURE: on a vsync rising edge:
    - frame_valid=0 and frame_done=1 for one cycle.
    - frame_err <= (err_flag | line_cnt != V_LINES).
    - frame_cnt increments.
    - Go to ARM.
  - Any state: sdram_init_done=0 forces WAIT_INIT next cycle. frame_valid drops, no frame_done is issued, and skip_cnt clears.
- Writes occur only in CAPTURE.
  - Pixels with pix_cnt >= H_PIXELS and lines with line_cnt >= V_LINES are not written (sys_we stays 0), which protects the SDRAM address range. The error flag is set.
- End of line (href falling edge in CAPTURE):
  - If the toggle is odd, the half pixel is dropped and the error flag is set.
  - If pix_cnt != H_PIXELS, the error flag is set.
  - line_cnt increments (saturating at V_LINES) and pix_cnt clears.
- Counter widths: pix_cnt is $clog2(H_PIXELS+1) bits and line_cnt is $clog2(V_LINES+1) bits, both saturating. skip_cnt is 8 bits.
- Reset (including mid-frame): every output is 0 on the next clk and the state is WAIT_INIT. The partial frame is abandoned with no frame_done.
- A vsync rising edge coinciding with the last low byte: the pixel is still written, and frame_valid falls on the same cycle as that sys_we.

Decomposition:
- Package ov7670_cap_pkg:
  - state enum {WAIT_INIT, WAIT_VS, SKIP, ARM, CAPTURE}
  - default H_PIXELS/V_LINES/SKIP_FRAMES constants
  - RGB565 field slice constants
- One natural sub-module: dvp_byte_pack. It covers input registering, the byte toggle and the 16-bit packing, and outputs pix_stb, pix_data, href_fall and odd_flag.

Test Plan:
All scenarios use H_PIXELS=4, V_LINES=2, SKIP_FRAMES=1.
- Reset/init: rst=1 then 0, sdram_init_done=0, full frames driven -> sys_we, frame_valid and frame_done stay 0 throughout.
- Skip and capture: init_done=1, 3 clean frames with bytes 0x01..0x10 per frame -> frame 1 not written. Frame 2 gives 8 sys_we with data 0x0102, 0x0304, ..., 0x0F10. frame_done pulses with frame_err=0 and frame_cnt=1.
- Enable mid-frame: init_done rises during a line of frame 0 -> no write until after the next vsync rising edge plus the skip frame.
- Long/odd line: a line of 5 pixels, then a line of 3 pixels plus 1 byte -> only 4+3 writes occur. frame_done has frame_err=1. The next clean frame gives frame_err=0.
- Extra line: 3 lines of 4 pixels -> 8 writes, frame_err=1.
- Abort: init_done drops or rst asserts after 5 pixels -> frame_valid=0 next clk, no frame_done. The capture restarts cleanly after the skip frame.
